// File: rtl/manchester_beacon.sv
// Manchester-encoded beacon: preamble, sync violation, MSB-first payload, optional parity, gap.
// Define MANCHESTER_BEACON_PARITY_EN to append an even-parity bit after the payload.
module manchester_beacon #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DIV        = 4,
   parameter int unsigned PREAMBLE   = 4,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             tx,
   output logic             tx_active,
   output logic             frame_done,
   output logic [WIDTH-1:0] count
);

   localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BIT_MAX = (PREAMBLE > WIDTH) ? ((PREAMBLE > 2) ? PREAMBLE : 2)
                                                        : ((WIDTH > 2) ? WIDTH : 2);
   localparam int unsigned BW      = $clog2(BIT_MAX + 1);

   localparam logic [PW-1:0] PRE_LAST      = PW'(DIV - 1);
   localparam logic [BW-1:0] PREAMBLE_LAST = BW'(PREAMBLE - 1);
   localparam logic [BW-1:0] SYNC_LAST     = BW'(1);
   localparam logic [BW-1:0] DATA_LAST     = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_SYNC     = 3'd2,
      S_DATA     = 3'd3,
`ifdef MANCHESTER_BEACON_PARITY_EN
      S_PARITY   = 3'd4,
`endif
      S_GAP      = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             half_q, half_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             parity_q, parity_d;
   logic             tx_q, tx_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic             start;
   logic             cur_bit;

   // Line level for a given position in the frame; bit b is sent as ~b then b.
   function automatic logic line_level(input state_e st, input logic half,
                                       input logic [BW-1:0] bit_idx, input logic b);
      case (st)
         S_PREAMBLE: line_level = half;
         S_SYNC:     line_level = (bit_idx == '0);
`ifdef MANCHESTER_BEACON_PARITY_EN
         S_PARITY,
`endif
         S_DATA:     line_level = half ? b : ~b;
         default:    line_level = IDLE_LEVEL;
      endcase
   endfunction

   assign data_ready = (state_q == S_IDLE) & en & mode;
   assign start      = en & (~mode | (data_valid & data_ready));

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      pre_d    = pre_q;
      half_d   = half_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      mode_d   = mode_q;
      count_d  = count_q;
      parity_d = parity_q;

      if (state_q == S_IDLE) begin
         if (start) begin
            state_d  = S_PREAMBLE;
            pre_d    = '0;
            half_d   = 1'b0;
            bit_d    = '0;
            mode_d   = mode;
            shift_d  = mode ? data_in : count_q;
            parity_d = mode ? ^data_in : ^count_q;
         end
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (!half_q) begin
            half_d = 1'b1;
         end else begin
            half_d = 1'b0;
            bit_d  = bit_q + BW'(1);
            case (state_q)
               S_PREAMBLE: if (bit_q == PREAMBLE_LAST) begin
                  state_d = S_SYNC;
                  bit_d   = '0;
               end
               S_SYNC: if (bit_q == SYNC_LAST) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end
               S_DATA: begin
                  shift_d = shift_q << 1;
                  if (bit_q == DATA_LAST) begin
`ifdef MANCHESTER_BEACON_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_GAP;
`endif
                     bit_d   = '0;
                  end
               end
`ifdef MANCHESTER_BEACON_PARITY_EN
               S_PARITY: begin
                  state_d = S_GAP;
                  bit_d   = '0;
               end
`endif
               S_GAP: begin
                  state_d = S_IDLE;
                  bit_d   = '0;
                  if (!mode_q) count_d = count_q + WIDTH'(1);
               end
               default: ;
            endcase
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end
   end

   // Outputs are registered from the next-state view so they line up with the state they describe.
   assign cur_bit  = (state_d == S_DATA) ? shift_d[WIDTH-1] : parity_d;
   assign tx_d     = line_level(state_d, half_d, bit_d, cur_bit);
   assign active_d = (state_d != S_IDLE);
   assign done_d   = (state_d == S_GAP) && half_d && (pre_d == PRE_LAST);

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pre_q    <= '0;
         half_q   <= 1'b0;
         bit_q    <= '0;
         shift_q  <= '0;
         mode_q   <= 1'b0;
         count_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= IDLE_LEVEL;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         mode_q   <= mode_d;
         count_q  <= count_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign tx         = tx_q;
   assign tx_active  = active_q;
   assign frame_done = done_q;
   assign count      = count_q;

endmodule

// File: tb/tb_manchester_beacon.sv
// Directed bench for manchester_beacon: DIV=2 and DIV=1 instances, hand-derived frame images.
// Honours MANCHESTER_BEACON_PARITY_EN the same way the design does.
module tb_manchester_beacon;

`ifdef MANCHESTER_BEACON_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int N2 = 4 * (4 + 2 + 8 + P + 1);
   localparam int N1 = 2 * (4 + 2 + 8 + P + 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_a = 1'b0, en_b = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       rdy_a, tx_a, act_a, done_a;
   logic       rdy_b, tx_b, act_b, done_b;
   logic [7:0] count_a, count_b;

   int n_checks = 0;
   int n_err    = 0;

   manchester_beacon #(.WIDTH(8), .DIV(2), .PREAMBLE(4), .IDLE_LEVEL(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode), .data_in(data_in),
      .data_valid(data_valid), .data_ready(rdy_a), .tx(tx_a), .tx_active(act_a),
      .frame_done(done_a), .count(count_a)
   );

   manchester_beacon #(.WIDTH(8), .DIV(1), .PREAMBLE(4), .IDLE_LEVEL(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode), .data_in(data_in),
      .data_valid(data_valid), .data_ready(rdy_b), .tx(tx_b), .tx_active(act_b),
      .frame_done(done_b), .count(count_b)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ones(input int n);
      return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
   endfunction

   // Expected tx image, cycle k of the frame in bit k.
   function automatic logic [63:0] exp_tx(input logic [7:0] p, input int div);
      logic        h[$];
      logic [63:0] v = '0;
      int          c = 0;
      for (int i = 0; i < 4; i++) begin
         h.push_back(1'b0);
         h.push_back(1'b1);
      end
      h.push_back(1'b1); h.push_back(1'b1); h.push_back(1'b0); h.push_back(1'b0);
      for (int i = 7; i >= 0; i--) begin
         h.push_back(~p[i]);
         h.push_back(p[i]);
      end
`ifdef MANCHESTER_BEACON_PARITY_EN
      h.push_back(~(^p));
      h.push_back(^p);
`endif
      h.push_back(1'b0); h.push_back(1'b0);
      foreach (h[k]) begin
         for (int d = 0; d < div; d++) begin
            v[c] = h[k];
            c++;
         end
      end
      return v;
   endfunction

   // Starts at an IDLE sample point; the first tick is the start edge. Ends on the IDLE sample after the frame.
   task automatic run_frame(input bit sel, input int n, input int drop_at, input int chg_at,
                            output logic [63:0] txv, output logic [63:0] actv,
                            output logic [63:0] donev, output logic [63:0] rdyv);
      txv = '0; actv = '0; donev = '0; rdyv = '0;
      tick();
      for (int i = 0; i < n; i++) begin
         txv[i]   = sel ? tx_b   : tx_a;
         actv[i]  = sel ? act_b  : act_a;
         donev[i] = sel ? done_b : done_a;
         rdyv[i]  = sel ? rdy_b  : rdy_a;
         if (i == drop_at) begin
            if (sel) en_b = 1'b0;
            else     en_a = 1'b0;
         end
         if (i == chg_at) begin
            mode    = 1'b0;
            data_in = 8'h3C;
         end
         tick();
      end
   endtask

   logic [63:0] txv, actv, donev, rdyv;
   int          act_cnt;

   initial begin
      // Reset state
      #2;
      check("rst_tx", tx_a, 0);
      check("rst_active", act_a, 0);
      check("rst_done", done_a, 0);
      check("rst_count", count_a, 0);
      check("rst_ready_en0", rdy_a, 0);
      en_a = 1'b1; mode = 1'b1; #1;
      check("rst_ready_en1_mode1", rdy_a, 1);

      // Release mid-cycle: no start before the first edge with rst_n high
      mode = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      check("no_start_before_edge", act_a, 0);

      // Reset at cycle 20 of a heartbeat frame
      tick();
      tick();
      check("hb_active_first_edge", act_a, 1);
      for (int i = 0; i < 20; i++) tick();
      rst_n = 1'b0; #1;
      check("midrst_tx", tx_a, 0);
      check("midrst_active", act_a, 0);
      check("midrst_done", done_a, 0);
      check("midrst_count", count_a, 0);
      en_a = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("midrst_count_after", count_a, 0);

      // Heartbeat frame, payload 0x00
      en_a = 1'b1; mode = 1'b0;
      run_frame(1'b0, N2, -1, -1, txv, actv, donev, rdyv);
      en_a = 1'b0;
      check("hb0_tx", txv, exp_tx(8'h00, 2));
      check("hb0_active", actv, ones(N2));
      check("hb0_done", donev, 64'd1 << (N2 - 1));
      check("hb0_idle_active", act_a, 0);
      check("hb0_idle_tx", tx_a, 0);
      check("hb0_count", count_a, 1);

      // External payload 0xA5; mode/data change mid-frame must be ignored
      mode = 1'b1; data_in = 8'hA5; data_valid = 1'b1; en_a = 1'b1; #1;
      check("a5_ready_idle", rdy_a, 1);
      run_frame(1'b0, N2, -1, 5, txv, actv, donev, rdyv);
      en_a = 1'b0;
      check("a5_tx", txv, exp_tx(8'hA5, 2));
      check("a5_ready_in_frame", rdyv, 0);
      check("a5_done", donev, 64'd1 << (N2 - 1));
      check("a5_count_unchanged", count_a, 1);

      // Heartbeat frames back to back until count reaches 0xFF
      data_valid = 1'b0; mode = 1'b0; en_a = 1'b1;
      for (int k = 0; k < 20000 && count_a !== 8'hFF; k++) tick();
      check("count_reach_ff", count_a, 8'hFF);
      run_frame(1'b0, N2, -1, -1, txv, actv, donev, rdyv);
      en_a = 1'b0;
      check("ff_tx", txv, exp_tx(8'hFF, 2));
      check("ff_count_wrap", count_a, 0);

      // en dropped at cycle 10: frame completes, no further frame
      en_a = 1'b1;
      run_frame(1'b0, N2, 10, -1, txv, actv, donev, rdyv);
      check("endrop_active", actv, ones(N2));
      check("endrop_done", donev, 64'd1 << (N2 - 1));
      check("endrop_tx", txv, exp_tx(8'h00, 2));
      act_cnt = 0;
      for (int i = 0; i < 2 * N2; i++) begin
         if (act_a) act_cnt++;
         tick();
      end
      check("endrop_no_next_frame", act_cnt, 0);
      check("endrop_count", count_a, 1);

      // DIV=1 instance, external payload 0x01
      mode = 1'b1; data_in = 8'h01; data_valid = 1'b1; en_b = 1'b1; #1;
      check("div1_ready_idle", rdy_b, 1);
      run_frame(1'b1, N1, 0, -1, txv, actv, donev, rdyv);
      check("div1_tx", txv, exp_tx(8'h01, 1));
      check("div1_active", actv, ones(N1));
      check("div1_done", donev, 64'd1 << (N1 - 1));
      check("div1_idle_active", act_b, 0);
      check("div1_count", count_b, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/manchester_beacon.md
MANCHESTER_BEACON -- requirements
Module: manchester_beacon

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, payload bits per frame, legal range 1..32.
REQ-002 SHALL provide parameter DIV, default 4, clk cycles per Manchester half-bit, legal range >=1.
REQ-003 SHALL provide parameter PREAMBLE, default 4, number of preamble bits (all value 1), legal range >=1.
REQ-004 SHALL provide parameter IDLE_LEVEL, default 0, tx level outside frames.
REQ-005 SHALL have ports, one per line:
  clk  input  1  single clock; all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  en  input  1  permits starting new frames
  mode  input  1  0 = heartbeat (internal counter payload), 1 = external payload
  data_in  input  WIDTH  external payload
  data_valid  input  1  data_in valid
  data_ready  output  1  block accepts data_in this cycle
  tx  output  1  registered Manchester line output
  tx_active  output  1  high while a frame is in progress
  frame_done  output  1  one-cycle pulse, last cycle of a frame
  count  output  WIDTH  heartbeat counter value

Function
REQ-006 SHALL implement FSM states IDLE, PREAMBLE, SYNC, DATA, PARITY (macro-dependent), GAP.
REQ-007 data_ready SHALL equal (state==IDLE) & en & mode, combinationally.
REQ-008 In IDLE, a frame SHALL start when en=1 and either mode=0 or data_valid&data_ready; payload latched that cycle (count if mode=0, data_in if mode=1).
REQ-009 mode and payload SHALL be sampled only at start; changes mid-frame SHALL have no effect.
REQ-010 At the edge after start, state SHALL be PREAMBLE and tx SHALL carry the first half-bit; each half-bit SHALL be held exactly DIV cycles.
REQ-011 Bit encoding: bit b SHALL be sent as half-bit ~b then half-bit b (1 = low->high).
REQ-012 PREAMBLE SHALL send PREAMBLE bits of value 1.
REQ-013 SYNC SHALL send a code violation: 2 half-bits high then 2 half-bits low (2 bit periods).
REQ-014 DATA SHALL send WIDTH payload bits MSB first.
REQ-015 GAP SHALL hold tx=IDLE_LEVEL for one bit period (2*DIV cycles).
REQ-016 Frame length SHALL be 2*DIV*(PREAMBLE+2+WIDTH+P+1) cycles, P=1 with parity, else 0.
REQ-017 frame_done SHALL pulse in the last GAP cycle; the next edge SHALL enter IDLE; a new frame may start in that IDLE cycle (one idle cycle minimum between frames).
REQ-018 tx_active SHALL be high in every non-IDLE state; tx SHALL be IDLE_LEVEL in IDLE.
REQ-019 count SHALL increment by 1, modulo 2^WIDTH, in the frame_done cycle of mode-0 frames only.
REQ-020 Deasserting en mid-frame SHALL not abort the frame; it completes, then block stays IDLE.
REQ-021 With DIV=1 every half-bit SHALL last one cycle with no dropped or repeated half-bits.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, tx=IDLE_LEVEL, tx_active=0, frame_done=0, count=0, prescaler and bit index 0.
REQ-023 Reset mid-frame SHALL abandon the frame with no frame_done and no count increment.
REQ-024 After release, first start SHALL occur no earlier than the first edge with rst_n high.

Configuration
REQ-025 Macro MANCHESTER_BEACON_PARITY_EN defined: PARITY state after DATA sends one even-parity bit (XOR of payload), Manchester encoded; P=1.
REQ-026 Macro undefined: no PARITY state, DATA proceeds directly to GAP; P=0.

Verification (WIDTH=8, DIV=2, PREAMBLE=4, IDLE_LEVEL=0)
REQ-027 Reset, en=1, mode=0 -> tx_active rises next edge; frame 60 cycles (64 with parity); payload 0x00 half-bits 10 x8; count=1 after frame_done.
REQ-028 mode=1, data_in=0xA5, data_valid=1 -> data_ready=1 one cycle; data half-bits 01 10 01 10 10 01 10 01; parity bit 0 (half-bits 10) when macro defined.
REQ-029 mode=0 with count=0xFF -> frame sends 0xFF, count wraps to 0x00 at frame_done.
REQ-030 rst_n low at cycle 20 of a frame -> tx=0, tx_active=0 immediately; no frame_done; count unchanged at 0.
REQ-031 en dropped at cycle 10 of a frame -> frame completes full 60 cycles, frame_done pulses once, no further frame.
REQ-032 DIV=1, mode=1, data_in=0x01 -> 30-cycle frame, final data half-bits 01, each half-bit one cycle.
